// File: rtl/geno_result_collector.sv
// Collects out-of-order DP engine scores into per-ID slots, then drains them
// in ascending ID order once the programmed number of jobs has returned.
module geno_result_collector #(
   parameter int SCORE_W = 32,
   parameter int WORDS   = 64,
   parameter int AW      = $clog2(WORDS)
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic                      i_start,
   input  logic [AW:0]               i_job_count,
   output logic                      o_geno_ready,
   input  logic                      i_geno_valid,
   input  logic signed [SCORE_W-1:0] i_geno_alignment_score,
   input  logic [AW-1:0]             i_geno_address_ID,
   output logic                      o_res_valid,
   input  logic                      i_res_ready,
   output logic signed [SCORE_W-1:0] o_res_score,
   output logic [AW-1:0]             o_res_address_ID,
   output logic                      o_res_last,
   output logic                      o_busy,
   output logic                      o_done,
   output logic                      o_err
);

   typedef enum logic [1:0] {S_IDLE, S_COLLECT, S_DRAIN} state_e;

   localparam logic [AW:0] WORDS_C = (AW+1)'(WORDS);

   state_e                     state_q, state_d;
   logic [AW:0]                job_q, job_d;
   logic [AW:0]                cnt_q, cnt_d;
   logic [AW:0]                idx_q, idx_d;
   logic [WORDS-1:0]           vld_q, vld_d;
   logic                       err_q, err_d;
   logic                       done_q, done_d;
   logic                       geno_ready_q, geno_ready_d;
   logic                       res_valid_q, res_valid_d;
   logic signed [SCORE_W-1:0]  res_score_q, res_score_d;
   logic [AW-1:0]              res_addr_q, res_addr_d;
   logic                       res_last_q, res_last_d;
   logic signed [SCORE_W-1:0]  mem_q [WORDS];
   logic                       mem_we;

   logic        accept, in_range, acc_new, last_hs, drain_adv;
   logic [AW:0] cnt_inc;

   assign accept    = i_geno_valid & geno_ready_q;
   assign in_range  = {1'b0, i_geno_address_ID} < job_q;
   assign acc_new   = accept & in_range & ~vld_q[i_geno_address_ID];
   assign cnt_inc   = cnt_q + 1'b1;
   assign drain_adv = ~res_valid_q | i_res_ready;
   assign last_hs   = (state_q == S_DRAIN) & res_valid_q & i_res_ready & res_last_q;

   // State register and all control/output flops.
   // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q      <= S_IDLE;
         job_q        <= '0;
         cnt_q        <= '0;
         idx_q        <= '0;
         vld_q        <= '0;
         err_q        <= 1'b0;
         done_q       <= 1'b0;
         geno_ready_q <= 1'b0;
         res_valid_q  <= 1'b0;
         res_score_q  <= '0;
         res_addr_q   <= '0;
         res_last_q   <= 1'b0;
      end else begin
         state_q      <= state_d;
         job_q        <= job_d;
         cnt_q        <= cnt_d;
         idx_q        <= idx_d;
         vld_q        <= vld_d;
         err_q        <= err_d;
         done_q       <= done_d;
         geno_ready_q <= geno_ready_d;
         res_valid_q  <= res_valid_d;
         res_score_q  <= res_score_d;
         res_addr_q   <= res_addr_d;
         res_last_q   <= res_last_d;
      end
   end

   // NOTE: score storage has no reset; the valid bitmap alone decides which slots hold data.
   always_ff @(posedge clk) begin
      if (mem_we) mem_q[i_geno_address_ID] <= i_geno_alignment_score;
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         S_IDLE:    if (i_start && i_job_count != '0) state_d = S_COLLECT;
         S_COLLECT: if (acc_new && cnt_inc == job_q) state_d = S_DRAIN;
         S_DRAIN:   if (last_hs) state_d = S_IDLE;
         default:   state_d = S_IDLE;
      endcase
   end

   // NOTE: every variable gets a default first so no path can infer a latch.
   always_comb begin
      job_d        = job_q;
      cnt_d        = cnt_q;
      idx_d        = idx_q;
      vld_d        = vld_q;
      err_d        = err_q;
      done_d       = 1'b0;
      mem_we       = 1'b0;
      res_valid_d  = res_valid_q;
      res_score_d  = res_score_q;
      res_addr_d   = res_addr_q;
      res_last_d   = res_last_q;
      geno_ready_d = (state_d == S_COLLECT);

      unique case (state_q)
         S_IDLE: begin
            if (i_start) begin
               err_d = 1'b0;
               if (i_job_count == '0) begin
                  done_d = 1'b1;
               end else begin
                  job_d = (i_job_count > WORDS_C) ? WORDS_C : i_job_count;
                  cnt_d = '0;
                  idx_d = '0;
                  vld_d = '0;
               end
            end
         end
         S_COLLECT: begin
            if (acc_new) begin
               mem_we                   = 1'b1;
               vld_d[i_geno_address_ID] = 1'b1;
               cnt_d                    = cnt_inc;
            end else if (accept) begin
               err_d = 1'b1;
            end
         end
         S_DRAIN: begin
            // Load the next beat whenever the output register is empty or being taken.
            if (drain_adv) begin
               if (idx_q < job_q) begin
                  res_valid_d = 1'b1;
                  res_score_d = mem_q[idx_q[AW-1:0]];
                  res_addr_d  = idx_q[AW-1:0];
                  res_last_d  = (idx_q == job_q - 1'b1);
                  idx_d       = idx_q + 1'b1;
               end else begin
                  res_valid_d = 1'b0;
                  res_last_d  = 1'b0;
               end
            end
            done_d = last_hs;
         end
         default: ;
      endcase
   end

   assign o_geno_ready     = geno_ready_q;
   assign o_res_valid      = res_valid_q;
   assign o_res_score      = res_score_q;
   assign o_res_address_ID = res_addr_q;
   assign o_res_last       = res_last_q;
   assign o_busy           = (state_q != S_IDLE);
   assign o_done           = done_q;
   assign o_err            = err_q;

endmodule

// File: tb/tb_geno_result_collector.sv
// Directed bench for geno_result_collector: out-of-order collect, in-order
// drain, backpressure, error handling, zero/full counts, reset and ignored start.
module tb_geno_result_collector;

   localparam int SW = 32;
   localparam int WD = 64;
   localparam int AW = 6;

   logic                 clk = 1'b0;
   logic                 rst_n;
   logic                 i_start;
   logic [AW:0]          i_job_count;
   logic                 o_geno_ready;
   logic                 i_geno_valid;
   logic signed [SW-1:0] i_geno_alignment_score;
   logic [AW-1:0]        i_geno_address_ID;
   logic                 o_res_valid;
   logic                 i_res_ready;
   logic signed [SW-1:0] o_res_score;
   logic [AW-1:0]        o_res_address_ID;
   logic                 o_res_last;
   logic                 o_busy;
   logic                 o_done;
   logic                 o_err;

   int pass_cnt  = 0;
   int total_cnt = 0;

   logic signed [SW-1:0] got_score[$];
   int                   got_addr[$];
   bit                   got_last[$];
   int                   got_cyc[$];

   geno_result_collector #(.SCORE_W(SW), .WORDS(WD)) dut (
      .clk                    (clk),
      .rst_n                  (rst_n),
      .i_start                (i_start),
      .i_job_count            (i_job_count),
      .o_geno_ready           (o_geno_ready),
      .i_geno_valid           (i_geno_valid),
      .i_geno_alignment_score (i_geno_alignment_score),
      .i_geno_address_ID      (i_geno_address_ID),
      .o_res_valid            (o_res_valid),
      .i_res_ready            (i_res_ready),
      .o_res_score            (o_res_score),
      .o_res_address_ID       (o_res_address_ID),
      .o_res_last             (o_res_last),
      .o_busy                 (o_busy),
      .o_done                 (o_done),
      .o_err                  (o_err)
   );

   always #5 clk = ~clk;

   initial begin
      #2ms;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic start(input int cnt);
      i_start     = 1'b1;
      i_job_count = (AW+1)'(cnt);
      step();
      i_start     = 1'b0;
   endtask

   task automatic send(input int id, input int score);
      i_geno_valid           = 1'b1;
      i_geno_address_ID      = AW'(id);
      i_geno_alignment_score = score;
      step();
      i_geno_valid           = 1'b0;
   endtask

   // Runs the drain phase, recording handshaken beats and checking hold stability and completion.
   task automatic drain(input int max_cyc, input bit bp);
      bit                   hold_v = 1'b0;
      bit                   fin    = 1'b0;
      logic signed [SW-1:0] hs;
      logic [AW-1:0]        ha;
      logic                 hl;
      got_score.delete(); got_addr.delete(); got_last.delete(); got_cyc.delete();
      for (int k = 0; k < max_cyc; k++) begin
         i_res_ready = bp ? (k % 4 == 0 || k % 4 == 3) : 1'b1;
         if (hold_v) begin
            total_cnt++;
            if (o_res_valid !== 1'b1 || o_res_score !== hs || o_res_address_ID !== ha || o_res_last !== hl)
               $display("FAIL hold_stable: got v=%0b s=%0d a=%0d l=%0b, want v=1 s=%0d a=%0d l=%0b",
                        o_res_valid, o_res_score, o_res_address_ID, o_res_last, hs, ha, hl);
            else pass_cnt++;
         end
         hold_v = o_res_valid && !i_res_ready;
         hs = o_res_score; ha = o_res_address_ID; hl = o_res_last;
         if (o_res_valid && i_res_ready) begin
            got_score.push_back(o_res_score);
            got_addr.push_back(int'(o_res_address_ID));
            got_last.push_back(o_res_last);
            got_cyc.push_back(k);
         end
         fin = o_res_valid && i_res_ready && o_res_last;
         step();
         if (fin) break;
      end
      i_res_ready = 1'b0;
      total_cnt++;
      if (fin !== 1'b1 || o_done !== 1'b1 || o_busy !== 1'b0)
         $display("FAIL drain_end: finished=%0b done=%0b busy=%0b, want 1 1 0", fin, o_done, o_busy);
      else pass_cnt++;
      step();
      total_cnt++;
      if (o_done !== 1'b0) $display("FAIL done_pulse_width: done=%0b, want 0", o_done);
      else pass_cnt++;
   endtask

   // Compares recorded beats against an expected list of scores for IDs 0..n-1.
   task automatic expect_beats(input string name, input int n, input int exp_s[]);
      total_cnt++;
      if (got_addr.size() != n) $display("FAIL %s_count: got %0d beats, want %0d", name, got_addr.size(), n);
      else pass_cnt++;
      for (int i = 0; i < n && i < got_addr.size(); i++) begin
         total_cnt++;
         if (got_addr[i] != i || got_score[i] !== SW'(exp_s[i]) || got_last[i] !== (i == n - 1))
            $display("FAIL %s_beat%0d: got (%0d,%0d,last=%0b), want (%0d,%0d,last=%0b)",
                     name, i, got_addr[i], got_score[i], got_last[i], i, exp_s[i], i == n - 1);
         else pass_cnt++;
      end
   endtask

   task automatic test_reset();
      total_cnt++;
      if ({o_geno_ready, o_res_valid, o_res_last, o_busy, o_done, o_err} !== 6'b0 ||
          o_res_score !== '0 || o_res_address_ID !== '0)
         $display("FAIL reset_outputs: rdy=%0b v=%0b l=%0b busy=%0b done=%0b err=%0b s=%0d a=%0d, want all 0",
                  o_geno_ready, o_res_valid, o_res_last, o_busy, o_done, o_err, o_res_score, o_res_address_ID);
      else pass_cnt++;
   endtask

   task automatic test_out_of_order();
      start(4);
      total_cnt++;
      if (o_busy !== 1'b1 || o_geno_ready !== 1'b1)
         $display("FAIL ooo_collect_entry: busy=%0b rdy=%0b, want 1 1", o_busy, o_geno_ready);
      else pass_cnt++;
      send(2, -5); send(0, 100); send(3, -32768); send(1, 7);
      total_cnt++;
      if (o_geno_ready !== 1'b0 || o_res_valid !== 1'b0 || o_busy !== 1'b1)
         $display("FAIL ooo_drain_entry: rdy=%0b v=%0b busy=%0b, want 0 0 1", o_geno_ready, o_res_valid, o_busy);
      else pass_cnt++;
      drain(20, 1'b0);
      expect_beats("ooo", 4, '{100, 7, -5, -32768});
      total_cnt++;
      if (got_cyc.size() != 4 || got_cyc[0] != 1 || got_cyc[3] != 4)
         $display("FAIL ooo_timing: first/last beat cycle %0d/%0d, want 1/4",
                  got_cyc.size() > 0 ? got_cyc[0] : -1, got_cyc.size() > 3 ? got_cyc[3] : -1);
      else pass_cnt++;
      total_cnt++;
      if (o_err !== 1'b0) $display("FAIL ooo_err: err=%0b, want 0", o_err);
      else pass_cnt++;
   endtask

   task automatic test_backpressure();
      start(3);
      send(1, 11); send(2, -22); send(0, 33);
      drain(40, 1'b1);
      expect_beats("bp", 3, '{33, 11, -22});
   endtask

   task automatic test_dup_range();
      bit [3:0] rdy;
      start(2);
      send(0, 10); rdy[0] = o_geno_ready;
      send(0, 99); rdy[1] = o_geno_ready;
      send(5, 1);  rdy[2] = o_geno_ready;
      total_cnt++;
      if (o_err !== 1'b1) $display("FAIL dup_err_set: err=%0b, want 1", o_err);
      else pass_cnt++;
      send(1, 20); rdy[3] = o_geno_ready;
      total_cnt++;
      if (rdy !== 4'b0111) $display("FAIL dup_ready_seq: got %4b (accept4..1), want 0111", rdy);
      else pass_cnt++;
      drain(20, 1'b0);
      expect_beats("dup", 2, '{10, 20});
      total_cnt++;
      if (o_err !== 1'b1) $display("FAIL dup_err_sticky: err=%0b, want 1", o_err);
      else pass_cnt++;
   endtask

   task automatic test_zero_count();
      start(0);
      total_cnt++;
      if (o_done !== 1'b1 || o_busy !== 1'b0 || o_geno_ready !== 1'b0 || o_err !== 1'b0)
         $display("FAIL zero_start: done=%0b busy=%0b rdy=%0b err=%0b, want 1 0 0 0", o_done, o_busy, o_geno_ready, o_err);
      else pass_cnt++;
      step();
      total_cnt++;
      if (o_done !== 1'b0 || o_busy !== 1'b0 || o_geno_ready !== 1'b0)
         $display("FAIL zero_after: done=%0b busy=%0b rdy=%0b, want 0 0 0", o_done, o_busy, o_geno_ready);
      else pass_cnt++;
   endtask

   task automatic test_full_count();
      int exp_s[] = new[WD];
      start(WD);
      for (int id = WD - 1; id >= 0; id--) begin
         exp_s[id] = id * 1000 - 31000;
         send(id, exp_s[id]);
      end
      total_cnt++;
      if (o_geno_ready !== 1'b0) $display("FAIL full_ready_drop: rdy=%0b, want 0", o_geno_ready);
      else pass_cnt++;
      drain(200, 1'b0);
      expect_beats("full", WD, exp_s);
   endtask

   task automatic test_reset_mid_batch();
      start(4);
      send(1, 5); send(1, 6);
      total_cnt++;
      if (o_err !== 1'b1 || o_busy !== 1'b1) $display("FAIL midrst_pre: err=%0b busy=%0b, want 1 1", o_err, o_busy);
      else pass_cnt++;
      rst_n = 1'b0;
      step();
      rst_n = 1'b1;
      test_reset();
      start(1);
      send(0, 42);
      drain(20, 1'b0);
      expect_beats("midrst", 1, '{42});
      total_cnt++;
      if (o_err !== 1'b0) $display("FAIL midrst_err: err=%0b, want 0", o_err);
      else pass_cnt++;
   endtask

   task automatic test_ignored_start();
      start(2);
      send(0, -1);
      i_start = 1'b1; i_job_count = 7'd8;
      step();
      i_start = 1'b0;
      total_cnt++;
      if (o_busy !== 1'b1 || o_geno_ready !== 1'b1)
         $display("FAIL ign_start_collect: busy=%0b rdy=%0b, want 1 1", o_busy, o_geno_ready);
      else pass_cnt++;
      i_start = 1'b1;
      send(1, -2);
      i_start = 1'b0;
      total_cnt++;
      if (o_geno_ready !== 1'b0 || o_busy !== 1'b1)
         $display("FAIL ign_start_final: rdy=%0b busy=%0b, want 0 1", o_geno_ready, o_busy);
      else pass_cnt++;
      drain(20, 1'b0);
      expect_beats("ign", 2, '{-1, -2});
   endtask

   initial begin
      rst_n = 1'b0; i_start = 1'b0; i_job_count = '0; i_geno_valid = 1'b0;
      i_geno_alignment_score = '0; i_geno_address_ID = '0; i_res_ready = 1'b0;
      step(); step();
      rst_n = 1'b1;
      test_reset();
      test_out_of_order();
      test_backpressure();
      test_dup_range();
      test_zero_count();
      test_full_count();
      test_reset_mid_batch();
      test_ignored_start();
      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule
